// File: rtl/cmp_sar_search.sv
// cmp_sar_search: successive-approximation search that drives the probe
// operand of a magnitude comparator and reads its le/gr/eq flags to recover
// the hidden operand. One start/done transaction per search, early exit on eq.
module cmp_sar_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             le,
  input  logic             gr,
  input  logic             eq,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE) + 1;

  localparam logic [IW-1:0]    I_TOP     = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_INIT  = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] PROBE_MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] probe_q,  probe_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;

  logic             flags_ok;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] next_bit;

  // Flags must be exactly one-hot; acc takes the probe when a lies above it,
  // and the next probe sets the next lower bit on top of the updated acc.
  always_comb begin
    flags_ok = $onehot({le, gr, eq});
    acc_upd  = gr ? probe_q : acc_q;
    next_bit = '0;
    if (idx_q != '0) begin
      next_bit = WIDTH'(1) << (idx_q - IW'(1));
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      probe_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and register updates for the search sequence.
  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = I_TOP;
          probe_d = PROBE_MSB;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_STEP;
        end
      end

      S_STEP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!flags_ok) begin
          result_d = acc_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else if (eq) begin
          result_d = probe_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          acc_d = acc_upd;
          if (idx_q == '0) begin
            result_d = acc_upd;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            probe_d = acc_upd | next_bit;
            cnt_d   = CNT_INIT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// Bench for cmp_sar_search: three instances at SETTLE=1,2,3, each facing a
// behavioural comparator holding a hidden operand.
module tb_cmp_sar_search;

  localparam int W  = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NI-1:0]    start_v;
  logic [NI-1:0]    bad_v;
  logic [W-1:0]     a_v      [NI];
  logic [NI-1:0]    le_w, gr_w, eq_w, busy_w, done_w, err_w;
  logic [W-1:0]     probe_w  [NI];
  logic [W-1:0]     result_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign le_w[g] = bad_v[g] | (a_v[g] < probe_w[g]);
    assign gr_w[g] = bad_v[g] | (a_v[g] > probe_w[g]);
    assign eq_w[g] = ~bad_v[g] & (a_v[g] == probe_w[g]);

    cmp_sar_search #(.WIDTH(W), .SETTLE(g + 1)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_v[g]),
      .le     (le_w[g]),
      .gr     (gr_w[g]),
      .eq     (eq_w[g]),
      .probe  (probe_w[g]),
      .busy   (busy_w[g]),
      .done   (done_w[g]),
      .result (result_w[g]),
      .err    (err_w[g])
    );
  end

  typedef struct {
    int          k;
    int unsigned res;
    int unsigned err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned probe_log[$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Steps taken: stops on the probe equal to a, i.e. after W - tz(a) probes.
  function automatic int unsigned steps_for(input int unsigned a);
    int unsigned tz = 0;
    if (a == 0) return W;
    while (((a >> tz) & 1) == 0) tz++;
    return W - tz;
  endfunction

  task automatic run(input int k, input int unsigned a, input bit bad, input bit mid_start);
    exp_t        e;
    exp_t        got_e;
    int unsigned lat;
    bit          seen;
    @(negedge clk);
    a_v[k]   = W'(a);
    bad_v[k] = bad;
    e.k   = k;
    e.res = bad ? 0 : a;
    e.err = bad ? 1 : 0;
    e.lat = bad ? (k + 1) : steps_for(a) * (k + 1);
    sb.push_back(e);
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    check($sformatf("busy_after_start s%0d a%0d", k + 1, a), busy_w[k], 1);
    probe_log.delete();
    probe_log.push_back(probe_w[k]);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_w[k]) begin
        seen = 1'b1;
      end else begin
        if (probe_w[k] != W'(probe_log[$])) probe_log.push_back(probe_w[k]);
        start_v[k] = mid_start && (lat == 2);
      end
    end
    start_v[k] = 1'b0;
    check($sformatf("done_seen s%0d a%0d", k + 1, a), seen, 1);
    got_e = sb.pop_front();
    check($sformatf("latency s%0d a%0d", k + 1, a), lat, got_e.lat);
    check($sformatf("result s%0d a%0d", k + 1, a), result_w[k], got_e.res);
    check($sformatf("err s%0d a%0d", k + 1, a), err_w[k], got_e.err);
    check($sformatf("busy_at_done s%0d a%0d", k + 1, a), busy_w[k], 0);
    // start while in DONE must be ignored; done is a single-cycle pulse
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    check($sformatf("done_pulse s%0d a%0d", k + 1, a), done_w[k], 0);
    check($sformatf("start_in_done s%0d a%0d", k + 1, a), busy_w[k], 0);
    check($sformatf("result_held s%0d a%0d", k + 1, a), result_w[k], got_e.res);
    bad_v[k] = 1'b0;
  endtask

  task automatic check_probes(input string tag, input int unsigned p0, input int unsigned p1,
                              input int unsigned p2, input int unsigned p3);
    int unsigned exp_p[4];
    exp_p[0] = p0; exp_p[1] = p1; exp_p[2] = p2; exp_p[3] = p3;
    check({tag, "_count"}, probe_log.size(), 4);
    for (int i = 0; i < 4 && i < probe_log.size(); i++)
      check($sformatf("%s_p%0d", tag, i), probe_log[i], exp_p[i]);
  endtask

  task automatic check_zero(input string tag, input int k);
    check({tag, "_probe"},  probe_w[k],  0);
    check({tag, "_busy"},   busy_w[k],   0);
    check({tag, "_done"},   done_w[k],   0);
    check({tag, "_result"}, result_w[k], 0);
    check({tag, "_err"},    err_w[k],    0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    bad_v   = '0;
    for (int k = 0; k < NI; k++) a_v[k] = '0;
    #2;
    for (int k = 0; k < NI; k++) check_zero($sformatf("reset_s%0d", k + 1), k);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 11, 1'b0, 1'b0);
    check_probes("probes_a11", 8, 12, 10, 11);
    run(0, 8, 1'b0, 1'b0);
    run(0, 0, 1'b0, 1'b0);
    check_probes("probes_a0", 8, 4, 2, 1);
    run(0, 15, 1'b0, 1'b0);
    check_probes("probes_a15", 8, 12, 14, 15);

    run(2, 5, 1'b0, 1'b1);

    run(0, 6, 1'b1, 1'b0);
    run(0, 6, 1'b0, 1'b0);

    // reset in the middle of a search clears everything at once
    @(negedge clk);
    a_v[0]     = 4'd11;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid", 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 13, 1'b0, 1'b0);

    for (int a = 0; a < 16; a++) run(0, a, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) run(1, a, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
